// File: rtl/alarm_timer_pkg.sv
// Shared definitions for the alarm timer and the downstream equation checker.
package alarm_timer_pkg;

    // Width of the timer value; also the width of the checker's OngoingTimer.
    localparam int unsigned TIMER_W = 7;

    // Alarm FSM state encoding.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2,
        SOLVED  = 2'd3
    } state_t;

endpackage

// File: rtl/alarm_timer_tick_prescaler.sv
// Divides the clock down to one tick every TICK_DIV enabled cycles.
// wrap_c lets the parent update its timer on the same edge that raises tick.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic Clock,
    input  logic Reset,
    input  logic enable,
    output logic tick,
    output logic wrap_c
);

    localparam int unsigned CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count;

    assign wrap_c = enable && (count == LAST);

    // Prescaler count and registered tick pulse; count frozen while disabled.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= wrap_c;
            if (wrap_c) begin
                count <= '0;
            end else if (enable) begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/alarm_timer.sv
// Alarm timer: keeps time, holds the alarm setpoint and raises AlarmRing
// until the equation checker reports a correct answer.
module alarm_timer
    import alarm_timer_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 50_000_000,
    parameter int unsigned TIMER_MAX = 99
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Enable,
    input  logic               SetAlarm,
    input  logic               Disarm,
    input  logic [TIMER_W-1:0] AlarmIn,
    input  logic               Correct,
    output logic [TIMER_W-1:0] TimerOut,
    output logic               Tick,
    output logic               AlarmRing,
    output logic               Armed,
    output logic               SetErr
);

    localparam logic [TIMER_W-1:0] TMAX = TIMER_W'(TIMER_MAX);

    logic               wrap_c;
    logic               alarm_ok_c;
    state_t             state;
    logic [TIMER_W-1:0] alarm_reg;

    assign alarm_ok_c = (AlarmIn <= TMAX);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .Clock  (Clock),
        .Reset  (Reset),
        .enable (Enable),
        .tick   (Tick),
        .wrap_c (wrap_c)
    );

    // Timer advances once per prescaler wrap and rolls over after TIMER_MAX.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            TimerOut <= '0;
        end else if (wrap_c) begin
            TimerOut <= (TimerOut == TMAX) ? '0 : TimerOut + TIMER_W'(1);
        end
    end

    // Alarm FSM with registered outputs; Disarm beats SetAlarm beats Correct/match.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= IDLE;
            alarm_reg <= '0;
            AlarmRing <= 1'b0;
            Armed     <= 1'b0;
            SetErr    <= 1'b0;
        end else begin
            SetErr <= SetAlarm && !alarm_ok_c && !Disarm;
            if (Disarm) begin
                state     <= IDLE;
                AlarmRing <= 1'b0;
                Armed     <= 1'b0;
            end else if (SetAlarm && alarm_ok_c) begin
                alarm_reg <= AlarmIn;
                state     <= ARMED;
                AlarmRing <= 1'b0;
                Armed     <= 1'b1;
            end else begin
                case (state)
                    ARMED: begin
                        if (TimerOut == alarm_reg) begin
                            state     <= RINGING;
                            AlarmRing <= 1'b1;
                            Armed     <= 1'b0;
                        end
                    end
                    RINGING: begin
                        if (Correct) begin
                            state     <= SOLVED;
                            AlarmRing <= 1'b0;
                        end
                    end
                    SOLVED: begin
                        // Wait until the matching unit has passed so it does not retrigger.
                        if (TimerOut != alarm_reg) begin
                            state <= ARMED;
                            Armed <= 1'b1;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        AlarmRing <= 1'b0;
                        Armed     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
